bus_dma_arbiter: RTL and testbench

- Two-requester arbiter between a CPU bus master (bus_req) and a DMA engine (dma_req) sharing one memory port.
- Grants one requester at a time with a one-cycle ack, then holds the matching enable for a fixed-length transfer and pulses done.
- Sits directly downstream of the request generators; produces the bus_ack/dma_ack/bus_enb/mem_enb/done handshake that the chapter-9 assertion set checks.

---
 rtl/bus_arb_pkg.sv | 14 +
 rtl/arb_pick.sv | 26 ++
 rtl/bus_dma_arbiter.sv | 112 +++++++++++
 tb/tb_bus_dma_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_arb_pkg : shared types for the CPU/DMA memory-port arbiter       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bus_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} arb_state_e;
  typedef enum logic {OWN_BUS = 1'b0, OWN_DMA = 1'b1} owner_e;

  localparam int XFER_CYCLES_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_pick : combinational round-robin / fixed-priority selector       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module arb_pick
  import bus_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic bus_req,
  input  logic dma_req,
  input  logic owner,
  output logic grant_valid,
  output logic grant_dma
);

  logic w_dma_wins_tie;

  // On a tie the round-robin mode serves whoever was not granted last.
  assign w_dma_wins_tie = RR_EN ? (owner == OWN_BUS) : 1'b1;
  assign grant_valid    = bus_req | dma_req;
  assign grant_dma      = dma_req & (~bus_req | w_dma_wins_tie);

endmodule
`default_nettype wire

// File: rtl/bus_dma_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_dma_arbiter : grants CPU bus or DMA a fixed-length memory window |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bus_dma_arbiter
  import bus_arb_pkg::*;
#(
  parameter int XFER_CYCLES = XFER_CYCLES_DEF,
  parameter bit RR_EN       = 1'b1,
  parameter int CNT_W       = $clog2(XFER_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bus_req,
  input  logic dma_req,
  output logic bus_ack,
  output logic dma_ack,
  output logic bus_enb,
  output logic mem_enb,
  output logic done,
  output logic abort,
  output logic owner
);

  arb_state_e       r_state;
  owner_e           r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_ack;
  logic             r_dma_ack;
  logic             r_bus_enb;
  logic             r_mem_enb;
  logic             r_done;
  logic             r_abort;

  logic             w_grant_valid;
  logic             w_grant_dma;
  logic             w_owner_req;

  arb_pick #(.RR_EN(RR_EN)) u_pick (
    .bus_req     (bus_req),
    .dma_req     (dma_req),
    .owner       (r_owner),
    .grant_valid (w_grant_valid),
    .grant_dma   (w_grant_dma)
  );

  assign w_owner_req = (r_owner == OWN_DMA) ? dma_req : bus_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_owner   <= OWN_DMA;
      r_cnt     <= '0;
      r_bus_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      r_bus_enb <= 1'b0;
      r_mem_enb <= 1'b0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_bus_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_state   <= GRANT;
            r_owner   <= w_grant_dma ? OWN_DMA : OWN_BUS;
            r_bus_ack <= ~w_grant_dma;
            r_dma_ack <= w_grant_dma;
          end
        end
        GRANT: begin
          r_state   <= XFER;
          r_cnt     <= CNT_W'(XFER_CYCLES - 1);
          r_bus_enb <= (r_owner == OWN_BUS);
          r_mem_enb <= (r_owner == OWN_DMA);
        end
        XFER: begin
          // A dropped request wins over completion, even on the last count.
          if (!w_owner_req) begin
            r_state   <= IDLE;
            r_bus_enb <= 1'b0;
            r_mem_enb <= 1'b0;
            r_abort   <= 1'b1;
          end else if (r_cnt == '0) begin
            r_state   <= DONE;
            r_bus_enb <= 1'b0;
            r_mem_enb <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_ack = r_bus_ack;
  assign dma_ack = r_dma_ack;
  assign bus_enb = r_bus_enb;
  assign mem_enb = r_mem_enb;
  assign done    = r_done;
  assign abort   = r_abort;
  assign owner   = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_bus_dma_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bus_dma_arbiter : directed + random bench with a timeline model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_bus_dma_arbiter;

  localparam int NI            = 3;
  localparam int XC [NI]       = '{4, 4, 1};
  localparam bit RRS [NI]      = '{1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bus_req = 1'b0;
  logic dma_req = 1'b0;

  logic [NI-1:0] bus_ack, dma_ack, bus_enb, mem_enb, done, abort, owner;
  logic [6:0]    obs [NI];

  int n_err = 0;
  int n_chk = 0;

  // Reference: position in the transaction timeline since the grant edge.
  // -1 idle, 0 ack, 1..X enable window, X+1 done.
  int pos  [NI];
  int who  [NI];
  int own  [NI];
  int abrt [NI];

  always #5 clk = ~clk;

  bus_dma_arbiter #(.XFER_CYCLES(4), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .dma_req(dma_req),
    .bus_ack(bus_ack[0]), .dma_ack(dma_ack[0]), .bus_enb(bus_enb[0]),
    .mem_enb(mem_enb[0]), .done(done[0]), .abort(abort[0]), .owner(owner[0])
  );

  bus_dma_arbiter #(.XFER_CYCLES(4), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .dma_req(dma_req),
    .bus_ack(bus_ack[1]), .dma_ack(dma_ack[1]), .bus_enb(bus_enb[1]),
    .mem_enb(mem_enb[1]), .done(done[1]), .abort(abort[1]), .owner(owner[1])
  );

  bus_dma_arbiter #(.XFER_CYCLES(1), .RR_EN(1'b1)) dut_one (
    .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .dma_req(dma_req),
    .bus_ack(bus_ack[2]), .dma_ack(dma_ack[2]), .bus_enb(bus_enb[2]),
    .mem_enb(mem_enb[2]), .done(done[2]), .abort(abort[2]), .owner(owner[2])
  );

  for (genvar g = 0; g < NI; g++) begin : g_obs
    assign obs[g] = {bus_ack[g], dma_ack[g], bus_enb[g], mem_enb[g],
                     done[g], abort[g], owner[g]};
  end

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input bit b, input bit d, input bit rn);
    int x;
    x = XC[k];
    abrt[k] = 0;
    if (!rn) begin
      pos[k] = -1;
      own[k] = 1;
    end else if (pos[k] < 0) begin
      if (b || d) begin
        if (b && d) who[k] = RRS[k] ? (1 - own[k]) : 1;
        else        who[k] = d ? 1 : 0;
        own[k] = who[k];
        pos[k] = 0;
      end
    end else if (pos[k] == 0) begin
      pos[k] = 1;
    end else if (pos[k] <= x) begin
      if (((who[k] == 1) ? d : b) == 1'b0) begin
        abrt[k] = 1;
        pos[k]  = -1;
      end else begin
        pos[k] = pos[k] + 1;
      end
    end else begin
      pos[k] = -1;
    end
  endtask

  function automatic logic [6:0] expect_vec(input int k);
    logic in_win;
    in_win = (pos[k] >= 1) && (pos[k] <= XC[k]);
    return {(pos[k] == 0) && (who[k] == 0), (pos[k] == 0) && (who[k] == 1),
            in_win && (who[k] == 0), in_win && (who[k] == 1),
            pos[k] == XC[k] + 1, abrt[k] != 0, own[k] != 0};
  endfunction

  // One clock: drive at negedge, model on the edge, compare just after it.
  task automatic cyc(input bit b, input bit d, input bit rn);
    @(negedge clk);
    bus_req = b;
    dma_req = d;
    rst_n   = rn;
    @(posedge clk);
    for (int k = 0; k < NI; k++) model_step(k, b, d, rn);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("model_i%0d", k), obs[k], expect_vec(k));
      check($sformatf("ack_mutex_i%0d", k), {6'b0, bus_ack[k] & dma_ack[k]}, 7'd0);
      check($sformatf("enb_mutex_i%0d", k), {6'b0, bus_enb[k] & mem_enb[k]}, 7'd0);
      check($sformatf("done_abort_i%0d", k), {6'b0, done[k] & abort[k]}, 7'd0);
      check($sformatf("ack_enb_i%0d", k),
            {6'b0, (bus_ack[k] | dma_ack[k]) & (bus_enb[k] | mem_enb[k])}, 7'd0);
    end
  endtask

  initial begin
    bit b, d, r;
    int bus_acks_fp;
    for (int k = 0; k < NI; k++) begin
      pos[k] = -1; who[k] = 0; own[k] = 1; abrt[k] = 0;
    end

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    check("reset_state", obs[0], 7'b0000001);

    // Single bus request: ack, four enable cycles, done.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 1'b1);
      if (i == 0)            check("sgl_ack", {6'b0, bus_ack[0]}, 7'd1);
      if (i >= 1 && i <= 4)  check("sgl_enb", {6'b0, bus_enb[0]}, 7'd1);
      if (i == 5)            check("sgl_done", {6'b0, done[0]}, 7'd1);
      check("sgl_no_dma", {6'b0, dma_ack[0] | mem_enb[0]}, 7'd0);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);

    // Both held: alternation on RR, DMA always on fixed priority.
    bus_acks_fp = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(1'b1, 1'b1, 1'b1);
      if (bus_ack[1]) bus_acks_fp++;
    end
    check("fp_never_bus", 7'(bus_acks_fp), 7'd0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1);

    // Abort: DMA drops after its second enable cycle while bus waits.
    cyc(1'b0, 1'b1, 1'b1);
    check("abt_ack", {6'b0, dma_ack[0]}, 7'd1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    check("abt_enb2", {6'b0, mem_enb[0]}, 7'd1);
    cyc(1'b1, 1'b0, 1'b1);
    check("abt_pulse", {5'b0, abort[0], done[0]}, 7'b0000010);
    check("abt_enb_low", {6'b0, mem_enb[0]}, 7'd0);
    cyc(1'b1, 1'b0, 1'b1);
    check("abt_bus_next", {6'b0, bus_ack[0]}, 7'd1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1);

    // Reset during the third bus enable cycle.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1);
    check("rst_pre_enb", {6'b0, bus_enb[0]}, 7'd1);
    cyc(1'b1, 1'b0, 1'b0);
    check("rst_mid", obs[0], 7'b0000001);
    cyc(1'b1, 1'b0, 1'b1);
    check("rst_ack", {6'b0, bus_ack[0]}, 7'd1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1);

    // Random stress with sticky requests and rare resets.
    b = 1'b0; d = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) b = ~b;
      if ($urandom_range(7) == 0) d = ~d;
      r = ($urandom_range(999) != 0);
      cyc(b, d, r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
